// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-to-execute bundle between ID, the ID/EX register and EX.
//   id_*           decode-stage bundle presented to the ID/EX register
//   flush          taken branch/jump resolved in EX; kill the ID instruction
//   ex_stall       EX/MEM cannot accept; hold the ID/EX register
//   ex_*           registered bundle driven into EX
//   stall_upstream hold PC and IF/ID this cycle
//   bubble_count   saturating count of inserted load-use bubbles
// master: the surrounding pipeline (drives id_*, flush, ex_stall)
// slave : id_ex_stage (drives ex_*, stall_upstream, bubble_count)
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [3:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        flush;
  logic        ex_stall;

  logic        ex_valid;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        stall_upstream;
  logic [15:0] bubble_count;

  modport master (
    output id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_uses_rs, id_uses_rt, id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, flush, ex_stall,
    input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           stall_upstream, bubble_count
  );

  modport slave (
    input  id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_uses_rs, id_uses_rt, id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, flush, ex_stall,
    output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           stall_upstream, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//   clk  pipeline clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  id_ex_stage_if.slave: ID bundle in, EX bundle / stall_upstream /
//        bubble_count out
// Edge priority: rst > flush (bubble) > ex_stall (hold) > load_use (bubble,
// count++) > capture ID (bubble when id_valid = 0).
module id_ex_stage (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_bundle_t;

  ex_bundle_t  ex_q;
  ex_bundle_t  id_bundle;
  logic [15:0] count_q;
  logic        load_use;

  // An invalid ID slot is captured as an all-zero bubble.
  always_comb begin
    id_bundle = '0;
    if (bus.id_valid) begin
      id_bundle.valid      = 1'b1;
      id_bundle.pc_plus4   = bus.id_pc_plus4;
      id_bundle.rs_data    = bus.id_rs_data;
      id_bundle.rt_data    = bus.id_rt_data;
      id_bundle.imm        = bus.id_imm;
      id_bundle.rs         = bus.id_rs;
      id_bundle.rt         = bus.id_rt;
      id_bundle.dest       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      id_bundle.alu_op     = bus.id_alu_op;
      id_bundle.alu_src    = bus.id_alu_src;
      id_bundle.reg_write  = bus.id_reg_write;
      id_bundle.mem_read   = bus.id_mem_read;
      id_bundle.mem_write  = bus.id_mem_write;
      id_bundle.mem_to_reg = bus.id_mem_to_reg;
    end
  end

  // $zero is never a hazard source.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.dest != 5'd0) &&
               bus.id_valid &&
               ((bus.id_uses_rs && (bus.id_rs == ex_q.dest)) ||
                (bus.id_uses_rt && (bus.id_rt == ex_q.dest)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      ex_q <= '0;
    end else if (bus.ex_stall) begin
      ex_q <= ex_q;
    end else if (load_use) begin
      ex_q <= '0;
      if (count_q != '1) count_q <= count_q + 16'd1;
    end else begin
      ex_q <= id_bundle;
    end
  end

  assign bus.stall_upstream = ~bus.flush & (bus.ex_stall | load_use);
  assign bus.bubble_count   = count_q;

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc_plus4   = ex_q.pc_plus4;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_dest       = ex_q.dest;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic,
// checked against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } id_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus_if ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus_if));

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  // Reference model state
  ex_t         m_ex = '0;
  logic [15:0] m_cnt = '0;
  id_t         cur;
  logic        cur_flush = 1'b0;
  logic        cur_stall = 1'b0;

  function automatic ex_t act_ex();
    ex_t a;
    a.valid = bus_if.ex_valid;       a.pc_plus4 = bus_if.ex_pc_plus4;
    a.rs_data = bus_if.ex_rs_data;   a.rt_data = bus_if.ex_rt_data;
    a.imm = bus_if.ex_imm;           a.rs = bus_if.ex_rs;
    a.rt = bus_if.ex_rt;             a.dest = bus_if.ex_dest;
    a.alu_op = bus_if.ex_alu_op;     a.alu_src = bus_if.ex_alu_src;
    a.reg_write = bus_if.ex_reg_write; a.mem_read = bus_if.ex_mem_read;
    a.mem_write = bus_if.ex_mem_write; a.mem_to_reg = bus_if.ex_mem_to_reg;
    return a;
  endfunction

  // Instruction in EX is a load writing a nonzero register that ID reads.
  function automatic bit hazard();
    bit ex_load;
    ex_load = m_ex.valid && m_ex.mem_read && m_ex.reg_write && m_ex.dest != 0;
    return ex_load && cur.valid &&
           ((cur.uses_rs && cur.rs == m_ex.dest) || (cur.uses_rt && cur.rt == m_ex.dest));
  endfunction

  function automatic bit model_stall();
    return !cur_flush && (cur_stall || hazard());
  endfunction

  function automatic ex_t id_to_ex(id_t x);
    ex_t e = '0;
    if (x.valid) begin
      e = '{valid: 1'b1, pc_plus4: x.pc_plus4, rs_data: x.rs_data, rt_data: x.rt_data,
            imm: x.imm, rs: x.rs, rt: x.rt, dest: (x.reg_dst ? x.rd : x.rt),
            alu_op: x.alu_op, alu_src: x.alu_src, reg_write: x.reg_write,
            mem_read: x.mem_read, mem_write: x.mem_write, mem_to_reg: x.mem_to_reg};
    end
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_ex = '0; m_cnt = '0;
    end else if (cur_flush) begin
      m_ex = '0;
    end else if (cur_stall) begin
      // hold
    end else if (hazard()) begin
      m_ex = '0;
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
    end else begin
      m_ex = id_to_ex(cur);
    end
  endtask

  task automatic drive(id_t x, logic fl, logic st);
    cur = x; cur_flush = fl; cur_stall = st;
    bus_if.id_valid = x.valid;       bus_if.id_pc_plus4 = x.pc_plus4;
    bus_if.id_rs_data = x.rs_data;   bus_if.id_rt_data = x.rt_data;
    bus_if.id_imm = x.imm;           bus_if.id_rs = x.rs;
    bus_if.id_rt = x.rt;             bus_if.id_rd = x.rd;
    bus_if.id_uses_rs = x.uses_rs;   bus_if.id_uses_rt = x.uses_rt;
    bus_if.id_alu_op = x.alu_op;     bus_if.id_alu_src = x.alu_src;
    bus_if.id_reg_dst = x.reg_dst;   bus_if.id_reg_write = x.reg_write;
    bus_if.id_mem_read = x.mem_read; bus_if.id_mem_write = x.mem_write;
    bus_if.id_mem_to_reg = x.mem_to_reg;
    bus_if.flush = fl;               bus_if.ex_stall = st;
  endtask

  // Advance one rising edge, update the model, settle past the edge.
  task automatic clock_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic id_t rand_id();
    id_t x;
    x.valid = ($urandom_range(0, 7) != 0);
    x.pc_plus4 = $urandom; x.rs_data = $urandom; x.rt_data = $urandom; x.imm = $urandom;
    x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
    x.rd = 5'($urandom_range(0, 3));
    x.uses_rs = 1'($urandom); x.uses_rt = 1'($urandom);
    x.alu_op = 4'($urandom); x.alu_src = 1'($urandom); x.reg_dst = 1'($urandom);
    x.reg_write = ($urandom_range(0, 3) != 0); x.mem_read = 1'($urandom);
    x.mem_write = 1'($urandom); x.mem_to_reg = 1'($urandom);
    return x;
  endfunction

  function automatic id_t lw(logic [4:0] rt, logic [4:0] rs);
    id_t x = rand_id();
    x.valid = 1; x.rs = rs; x.rt = rt; x.rd = 5'd0; x.uses_rs = 1; x.uses_rt = 0;
    x.alu_op = 4'h0; x.alu_src = 1; x.reg_dst = 0; x.reg_write = 1;
    x.mem_read = 1; x.mem_write = 0; x.mem_to_reg = 1;
    return x;
  endfunction

  function automatic id_t add(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    id_t x = rand_id();
    x.valid = 1; x.rs = rs; x.rt = rt; x.rd = rd; x.uses_rs = 1; x.uses_rt = 1;
    x.alu_op = 4'h2; x.alu_src = 0; x.reg_dst = 1; x.reg_write = 1;
    x.mem_read = 0; x.mem_write = 0; x.mem_to_reg = 0;
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(rand_id(), 1'b0, 1'b0);
    @(negedge clk); #1;
    tests_run++;
    if (act_ex() !== ex_t'('0)) begin
      tests_failed++; $display("FAIL reset_ex: got %h want 0", act_ex());
    end
    tests_run++;
    if (bus_if.bubble_count !== 16'd0) begin
      tests_failed++; $display("FAIL reset_count: got %h want 0", bus_if.bubble_count);
    end
    tests_run++;
    if (bus_if.stall_upstream !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b want 0", bus_if.stall_upstream);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ex = '0; m_cnt = '0;
  endtask

  task automatic test_capture();
    id_t x = rand_id();
    x.valid = 1; x.imm = 32'hFFFF_FFFF; x.rs = 0; x.rt = 8; x.rd = 0; x.uses_rs = 1;
    x.uses_rt = 0; x.alu_src = 1; x.reg_dst = 0; x.reg_write = 1; x.mem_read = 0;
    x.mem_write = 0; x.mem_to_reg = 0; x.alu_op = 4'h1;
    @(negedge clk);
    drive(x, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b0) begin
      tests_failed++; $display("FAIL capture_stall: got %b want 0", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (act_ex() !== m_ex) begin
      tests_failed++; $display("FAIL capture_bundle: got %h want %h", act_ex(), m_ex);
    end
    tests_run++;
    if (bus_if.ex_imm !== 32'hFFFF_FFFF || bus_if.ex_dest !== 5'd8 ||
        bus_if.ex_reg_write !== 1'b1 || bus_if.ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL capture_addiu: got imm=%h dest=%0d rw=%b v=%b want imm=ffffffff dest=8 rw=1 v=1",
               bus_if.ex_imm, bus_if.ex_dest, bus_if.ex_reg_write, bus_if.ex_valid);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] c0 = m_cnt;
    @(negedge clk); drive(lw(5'd9, 5'd0), 1'b0, 1'b0); clock_edge();
    @(negedge clk); drive(add(5'd9, 5'd11, 5'd12), 1'b0, 1'b0); #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b1) begin
      tests_failed++; $display("FAIL lu_stall: got %b want 1", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (act_ex() !== ex_t'('0) || bus_if.bubble_count !== c0 + 16'd1) begin
      tests_failed++;
      $display("FAIL lu_bubble: got ex=%h cnt=%h want ex=0 cnt=%h", act_ex(), bus_if.bubble_count, c0 + 16'd1);
    end
    #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b0) begin
      tests_failed++; $display("FAIL lu_one_cycle: got %b want 0", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (act_ex() !== m_ex || bus_if.ex_dest !== 5'd12 || bus_if.ex_valid !== 1'b1) begin
      tests_failed++; $display("FAIL lu_release: got %h want %h", act_ex(), m_ex);
    end
  endtask

  task automatic test_no_hazard();
    logic [15:0] c0 = m_cnt;
    id_t x;
    @(negedge clk); drive(lw(5'd9, 5'd0), 1'b0, 1'b0); clock_edge();
    x = add(5'd10, 5'd9, 5'd12); x.uses_rt = 0;
    @(negedge clk); drive(x, 1'b0, 1'b0); #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b0) begin
      tests_failed++; $display("FAIL nohaz_rs10_stall: got %b want 0", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (act_ex() !== m_ex || bus_if.bubble_count !== c0) begin
      tests_failed++;
      $display("FAIL nohaz_rs10: got ex=%h cnt=%h want ex=%h cnt=%h", act_ex(), bus_if.bubble_count, m_ex, c0);
    end
    @(negedge clk); drive(lw(5'd0, 5'd0), 1'b0, 1'b0); clock_edge();
    @(negedge clk); drive(add(5'd0, 5'd0, 5'd3), 1'b0, 1'b0); #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b0) begin
      tests_failed++; $display("FAIL nohaz_zero_stall: got %b want 0", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (act_ex() !== m_ex || bus_if.bubble_count !== c0) begin
      tests_failed++;
      $display("FAIL nohaz_zero: got ex=%h cnt=%h want ex=%h cnt=%h", act_ex(), bus_if.bubble_count, m_ex, c0);
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0 = m_cnt;
    @(negedge clk); drive(lw(5'd9, 5'd0), 1'b0, 1'b0); clock_edge();
    @(negedge clk); drive(add(5'd9, 5'd9, 5'd4), 1'b1, 1'b1); #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b0) begin
      tests_failed++; $display("FAIL flush_stall: got %b want 0", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (act_ex() !== ex_t'('0) || bus_if.bubble_count !== c0) begin
      tests_failed++;
      $display("FAIL flush_bubble: got ex=%h cnt=%h want ex=0 cnt=%h", act_ex(), bus_if.bubble_count, c0);
    end
  endtask

  task automatic test_ex_stall();
    ex_t held;
    id_t nxt;
    @(negedge clk); drive(add(5'd1, 5'd2, 5'd3), 1'b0, 1'b0); clock_edge();
    held = m_ex;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(rand_id(), 1'b0, 1'b1); #1;
      tests_run++;
      if (bus_if.stall_upstream !== 1'b1) begin
        tests_failed++; $display("FAIL hold_stall_%0d: got %b want 1", i, bus_if.stall_upstream);
      end
      clock_edge();
      tests_run++;
      if (act_ex() !== held) begin
        tests_failed++; $display("FAIL hold_bundle_%0d: got %h want %h", i, act_ex(), held);
      end
    end
    nxt = add(5'd2, 5'd3, 5'd7);
    @(negedge clk); drive(nxt, 1'b0, 1'b0); clock_edge();
    tests_run++;
    if (act_ex() !== id_to_ex(nxt)) begin
      tests_failed++; $display("FAIL hold_release: got %h want %h", act_ex(), id_to_ex(nxt));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0 = m_cnt;
    @(negedge clk); drive(lw(5'd9, 5'd0), 1'b0, 1'b0); clock_edge();
    @(negedge clk); drive(lw(5'd10, 5'd9), 1'b0, 1'b0); clock_edge();
    @(negedge clk); clock_edge();
    @(negedge clk); drive(add(5'd10, 5'd1, 5'd2), 1'b0, 1'b0); #1;
    tests_run++;
    if (bus_if.stall_upstream !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_stall: got %b want 1", bus_if.stall_upstream);
    end
    clock_edge();
    tests_run++;
    if (bus_if.bubble_count !== c0 + 16'd2) begin
      tests_failed++; $display("FAIL b2b_count: got %h want %h", bus_if.bubble_count, c0 + 16'd2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(rand_id(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      #1;
      tests_run++;
      if (bus_if.stall_upstream !== model_stall()) begin
        tests_failed++; $display("FAIL rand_stall_%0d: got %b want %b", i, bus_if.stall_upstream, model_stall());
      end
      clock_edge();
      tests_run++;
      if (act_ex() !== m_ex || bus_if.bubble_count !== m_cnt) begin
        tests_failed++;
        $display("FAIL rand_state_%0d: got ex=%h cnt=%h want ex=%h cnt=%h", i, act_ex(), bus_if.bubble_count, m_ex, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    #1 release dut.count_q;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(lw(5'd9, 5'd0), 1'b0, 1'b0); clock_edge();
      @(negedge clk); drive(add(5'd9, 5'd9, 5'd5), 1'b0, 1'b0); clock_edge();
      tests_run++;
      if (bus_if.bubble_count !== 16'hFFFF || bus_if.bubble_count !== m_cnt) begin
        tests_failed++; $display("FAIL sat_%0d: got %h want ffff", i, bus_if.bubble_count);
      end
    end
  endtask

  task automatic test_async_reset();
    id_t x;
    @(negedge clk); drive(lw(5'd5, 5'd0), 1'b0, 1'b0); clock_edge();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (act_ex() !== ex_t'('0) || bus_if.bubble_count !== 16'd0 || bus_if.stall_upstream !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_rst: got ex=%h cnt=%h stall=%b want all 0", act_ex(), bus_if.bubble_count, bus_if.stall_upstream);
    end
    m_ex = '0; m_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    x = add(5'd1, 5'd2, 5'd6);
    drive(x, 1'b0, 1'b0);
    clock_edge();
    tests_run++;
    if (act_ex() !== id_to_ex(x)) begin
      tests_failed++; $display("FAIL async_rst_capture: got %h want %h", act_ex(), id_to_ex(x));
    end
  endtask

  initial begin
    drive(rand_id(), 1'b0, 1'b0);
    test_reset();
    test_capture();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_ex_stall();
    test_back_to_back();
    test_random();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
